// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Producer side of the 9-bit instruction interface consumed by the control
// unit. It holds the program counter and reads a synchronous instruction
// memory. Each instruction word is presented with a valid/ready handshake.
// Jump targets come from a small programmable lookup table (LUT), because a
// 9-bit instruction cannot carry an absolute target.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 pulse: begin execution at PC 0 (from IDLE or DONE)
//   done                  sticky: program reached HALT_WORD
//   imem_en / imem_addr   instruction-memory read request
//   imem_rdata            read data, valid the cycle after imem_en
//   instr_o / pc_o        presented instruction and its PC
//   instr_valid / ready   handshake with the control unit
//   redirect_i            taken jump for the instruction being accepted
//   target_idx_i          LUT index that supplies the jump target
//   lut_we/waddr/wdata    LUT write port (honoured only in IDLE or DONE)
//   issue_count           count of accepted instructions
//
// Optional feature, selected by the macro INSTR_FETCH_PERF_CNT_EN:
//   defined   -> issue_count is a saturating 16-bit handshake counter
//   undefined -> issue_count is tied to zero
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int                  PC_W      = 10,
    parameter int                  INSTR_W   = 9,
    parameter int                  LUT_AW    = 4,
    parameter logic [INSTR_W-1:0]  HALT_WORD = 9'h1FF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                imem_en,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr_o,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [PC_W-1:0]     pc_o,
    input  logic                redirect_i,
    input  logic [LUT_AW-1:0]   target_idx_i,
    input  logic                lut_we,
    input  logic [LUT_AW-1:0]   lut_waddr,
    input  logic [PC_W-1:0]     lut_wdata,
    output logic [15:0]         issue_count
);

    localparam int LUT_N = 1 << LUT_AW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [PC_W-1:0]    lut_q [LUT_N];
    logic [PC_W-1:0]    lut_d [LUT_N];

    logic               handshake;
    logic               start_ok;
    logic               idle_or_done;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign handshake    = (state_q == S_ISSUE) && valid_q && instr_ready;
    assign start_ok     = start && idle_or_done;

    // Next-state logic for the FSM, PC, presented instruction and LUT.
    // The LUT is only writable while no program is running, so a redirect
    // always sees a stable table.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = done_q;
        lut_d    = lut_q;

        if (lut_we && idle_or_done) begin
            lut_d[lut_waddr] = lut_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                instr_d  = imem_rdata;
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (instr_q == HALT_WORD) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Redirect reads the registered table: a same-cycle
                        // write could never happen here anyway.
                        if (redirect_i) begin
                            pc_d = lut_q[target_idx_i];
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (start_ok) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight fetch immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            lut_q    <= lut_d;
        end
    end

    // The address is forced to zero outside FETCH so the memory bus is
    // quiet whenever no read is requested.
    assign imem_en     = (state_q == S_FETCH);
    assign imem_addr   = (state_q == S_FETCH) ? pc_q : '0;
    assign instr_o     = instr_q;
    assign pc_o        = pc_out_q;
    assign instr_valid = valid_q;
    assign done        = done_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts every accepted instruction, including the halt word; a new
    // run clears it and it sticks at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (start_ok) begin
            cnt_d = '0;
        end else if (handshake && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign issue_count = cnt_q;
`else
    assign issue_count = 16'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: a behavioural synchronous memory,
// a vector table for the basic three-instruction program, and hand-written
// sequences for back-pressure, redirect, PC wrap, async reset and restart.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_rdata;
    logic [8:0]  instr_o;
    logic        instr_valid;
    logic        instr_ready;
    logic [9:0]  pc_o;
    logic        redirect_i;
    logic [3:0]  target_idx_i;
    logic        lut_we;
    logic [3:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic [15:0] issue_count;

    logic [8:0]  mem [1024];

    int passCount;
    int totalCount;

`ifdef INSTR_FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [8:0] instr;
        logic [9:0] pc;
        int         gap;
    } vec_t;

    vec_t vecs [3];

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .done         (done),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_o      (instr_o),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_o         (pc_o),
        .redirect_i   (redirect_i),
        .target_idx_i (target_idx_i),
        .lut_we       (lut_we),
        .lut_waddr    (lut_waddr),
        .lut_wdata    (lut_wdata),
        .issue_count  (issue_count)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after imem_en.
    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= mem[imem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rdy,
                                 input logic redir, input logic [3:0] idx);
        start        = st;
        instr_ready  = rdy;
        redirect_i   = redir;
        target_idx_i = idx;
    endtask

    task automatic lutWrite(input logic [3:0] addr, input logic [9:0] data);
        lut_we    = 1'b1;
        lut_waddr = addr;
        lut_wdata = data;
        tick();
        lut_we    = 1'b0;
    endtask

    // Advances at least one edge, then until instr_valid rises or the
    // budget expires; returns the number of edges taken.
    task automatic waitValid(input string name, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!instr_valid && cyc < 20);
        checkOutput({name, " valid"}, 32'(instr_valid), 32'h1);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        passCount  = 0;
        totalCount = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
        clearMem();

        vecs[0] = '{instr: 9'h012, pc: 10'h000, gap: 2};
        vecs[1] = '{instr: 9'h034, pc: 10'h001, gap: 3};
        vecs[2] = '{instr: 9'h1FF, pc: 10'h002, gap: 3};

        // ---------------- reset state ----------------
        #2;
        checkOutput("rst valid",   32'(instr_valid), 32'h0);
        checkOutput("rst done",    32'(done),        32'h0);
        checkOutput("rst imem_en", 32'(imem_en),     32'h0);
        checkOutput("rst instr",   32'(instr_o),     32'h0);
        checkOutput("rst pc_o",    32'(pc_o),        32'h0);
        checkOutput("rst count",   32'(issue_count), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- basic program, ready held high ----------------
        mem[0] = 9'h012;
        mem[1] = 9'h034;
        mem[2] = 9'h1FF;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput("t1 fetch en",   32'(imem_en),   32'h1);
        checkOutput("t1 fetch addr", 32'(imem_addr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            waitValid("t1", cyc);
            checkOutput("t1 gap",   32'(cyc),     32'(vecs[i].gap));
            checkOutput("t1 instr", 32'(instr_o), 32'(vecs[i].instr));
            checkOutput("t1 pc_o",  32'(pc_o),    32'(vecs[i].pc));
        end
        tick();
        checkOutput("t1 done",        32'(done),        32'h1);
        checkOutput("t1 valid after", 32'(instr_valid), 32'h0);
        checkOutput("t1 count",       32'(issue_count), PERF ? 32'h3 : 32'h0);
        tick();
        checkOutput("t1 done sticky", 32'(done),        32'h1);
        // Async reset in DONE clears done before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t1 async done", 32'(done), 32'h0);
        doReset();

        // ---------------- back-pressure ----------------
        clearMem();
        mem[0] = 9'h055;
        mem[1] = 9'h066;
        mem[2] = 9'h1FF;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        waitValid("t2", cyc);
        checkOutput("t2 instr", 32'(instr_o), 32'h055);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t2 hold valid", 32'(instr_valid), 32'h1);
            checkOutput("t2 hold instr", 32'(instr_o),     32'h055);
            checkOutput("t2 hold pc",    32'(pc_o),        32'h000);
            checkOutput("t2 hold en",    32'(imem_en),     32'h0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t2 hs valid", 32'(instr_valid), 32'h0);
        checkOutput("t2 hs en",    32'(imem_en),     32'h1);
        checkOutput("t2 hs addr",  32'(imem_addr),   32'h001);
        waitValid("t2b", cyc);
        checkOutput("t2 next gap",   32'(cyc),     32'h2);
        checkOutput("t2 next pc",    32'(pc_o),    32'h001);
        checkOutput("t2 next instr", 32'(instr_o), 32'h066);
        doReset();

        // ---------------- redirect through LUT ----------------
        clearMem();
        mem[0]     = 9'h077;
        mem[10'h40] = 9'h0AA;
        lutWrite(4'd3, 10'h040);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        waitValid("t3", cyc);
        checkOutput("t3 instr", 32'(instr_o), 32'h077);
        // Redirect without ready must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
        tick();
        checkOutput("t3 no hs valid", 32'(instr_valid), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t3 redir en",   32'(imem_en),   32'h1);
        checkOutput("t3 redir addr", 32'(imem_addr), 32'h040);
        waitValid("t3b", cyc);
        checkOutput("t3 redir pc",    32'(pc_o),    32'h040);
        checkOutput("t3 redir instr", 32'(instr_o), 32'h0AA);
        // LUT write attempted while in ISSUE must not land.
        lutWrite(4'd3, 10'h123);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t3 lut locked", 32'(imem_addr), 32'h040);
        doReset();

        // ---------------- PC wrap (LUT write with start on same edge) ----------------
        clearMem();
        mem[0]      = 9'h002;
        mem[10'h3FF] = 9'h001;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        lutWrite(4'd5, 10'h3FF);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t4 start en", 32'(imem_en), 32'h1);
        waitValid("t4", cyc);
        checkOutput("t4 instr", 32'(instr_o), 32'h002);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t4 top addr", 32'(imem_addr), 32'h3FF);
        waitValid("t4b", cyc);
        checkOutput("t4 top pc",    32'(pc_o),    32'h3FF);
        checkOutput("t4 top instr", 32'(instr_o), 32'h001);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t4 wrap en",   32'(imem_en),   32'h1);
        checkOutput("t4 wrap addr", 32'(imem_addr), 32'h000);
        waitValid("t4c", cyc);
        checkOutput("t4 wrap pc", 32'(pc_o), 32'h000);
        doReset();

        // ---------------- async reset mid-LOAD and mid-ISSUE ----------------
        clearMem();
        mem[0] = 9'h011;
        mem[1] = 9'h022;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        waitValid("t5", cyc);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t5 fetch addr", 32'(imem_addr), 32'h001);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 async valid", 32'(instr_valid), 32'h0);
        checkOutput("t5 async en",    32'(imem_en),     32'h0);
        checkOutput("t5 async instr", 32'(instr_o),     32'h0);
        checkOutput("t5 async done",  32'(done),        32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("t5 idle valid", 32'(instr_valid), 32'h0);
        checkOutput("t5 idle en",    32'(imem_en),     32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t5 restart addr", 32'(imem_addr), 32'h000);
        checkOutput("t5 restart en",   32'(imem_en),   32'h1);
        waitValid("t5b", cyc);
        checkOutput("t5 restart instr", 32'(instr_o), 32'h011);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 issue reset valid", 32'(instr_valid), 32'h0);
        doReset();

        // ---------------- start ignored mid-run, restart from DONE ----------------
        clearMem();
        mem[0] = 9'h1FF;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        waitValid("t6", cyc);
        checkOutput("t6 gap with start", 32'(cyc),     32'h2);
        checkOutput("t6 instr",          32'(instr_o), 32'h1FF);
        tick();
        tick();
        checkOutput("t6 start in issue", 32'(instr_valid), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t6 done",  32'(done),        32'h1);
        checkOutput("t6 count", 32'(issue_count), PERF ? 32'h1 : 32'h0);
        tick();
        checkOutput("t6 stays done", 32'(imem_en), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t6 restart done",  32'(done),        32'h0);
        checkOutput("t6 restart en",    32'(imem_en),     32'h1);
        checkOutput("t6 restart addr",  32'(imem_addr),   32'h000);
        checkOutput("t6 restart count", 32'(issue_count), 32'h0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
